arb_rr_mux: RTL and testbench
=============================

ARB_RR_MUX -- requirements
Module: arb_rr_mux

Interface
REQ-001 Parameter DAT_T, default logic [8-1:0], data type of one beat.
REQ-002 Parameter WIDTH, default 9, number of requesters (WIDTH >= 2).
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req_vld  input  WIDTH  per-requester beat valid.
REQ-006 Port req_lst  input  WIDTH  per-requester last beat of packet.
REQ-007 Port req_dat  input  DAT_T [WIDTH-1:0]  per-requester beat data.
REQ-008 Port req_rdy  output  WIDTH  per-requester ready; combinational.
REQ-009 Port out_vld  output  1  registered output beat valid.
REQ-010 Port out_lst  output  1  registered output last flag.
REQ-011 Port out_dat  output  DAT_T  registered output data.
REQ-012 Port out_rdy  input  1  downstream ready.
REQ-013 Port gnt  output  WIDTH  current one-hot grant (all zero = none); combinational.

Function
REQ-014 Beat transfer on requester i SHALL occur when req_vld[i] & req_rdy[i]; at most one per cycle.
REQ-015 Load enable acc SHALL be ~out_vld | out_rdy.
REQ-016 req_rdy SHALL equal gnt when acc=1, else all zero.
REQ-017 Unlocked: gnt SHALL select first index with req_vld set, searching cyclically ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1; zero if no req_vld.
REQ-018 Locked: gnt SHALL equal the registered owner one-hot, regardless of req_vld of any requester.
REQ-019 Two states, UNLOCKED/LOCKED: transfer with req_lst=0 SHALL go to LOCKED and register owner=gnt; transfer with req_lst=1 SHALL go to UNLOCKED.
REQ-020 While LOCKED, owner dropping req_vld SHALL NOT release the lock; no other requester is granted.
REQ-021 On transfer with req_lst=1 from index i, ptr SHALL become (i+1) mod WIDTH (WIDTH-1 wraps to 0); otherwise ptr holds.
REQ-022 On transfer: next cycle out_vld=1, out_dat=req_dat[i], out_lst=req_lst[i]; latency exactly 1 cycle.
REQ-023 No transfer and out_rdy=1: out_vld SHALL clear; out_dat/out_lst hold.
REQ-024 out_vld & ~out_rdy: out_vld/out_dat/out_lst SHALL hold stable; no transfer.
REQ-025 Transfer and out_rdy=1 in same cycle: new beat loaded, no bubble; sustained throughput 1 beat/cycle.
REQ-026 Data path SHALL be a one-hot mux of req_dat by gnt; out_vld SHALL never depend combinationally on inputs.
REQ-027 req_rdy/gnt SHALL depend combinationally only on req_vld, out_vld, out_rdy and state, never on req_dat or req_lst.

Reset
REQ-028 rst_n=0 SHALL asynchronously force out_vld=0, out_lst=0, out_dat='0, ptr=0, state UNLOCKED, owner='0.
REQ-029 While rst_n=0, gnt and req_rdy SHALL follow REQ-016/017 with reset state; no transfer SHALL update state.
REQ-030 Reset asserted mid-packet SHALL drop the lock and the pending output beat; first grant after release follows ptr=0.

Verification (WIDTH=9, DAT_T 8 bit, req_dat[i]=i)
REQ-031 Idle: req_vld=0 -> gnt=0, req_rdy=0, out_vld stays 0.
REQ-032 Round-robin: all req_vld=1, req_lst=1, out_rdy=1 for 18 cycles -> out_dat sequence 0,1,...,8,0,...,8, out_vld=1 from cycle 2.
REQ-033 Packet lock: req 3 sends 3 beats (lst on 3rd) while req 4 valid -> out_dat 3,3,3 then 4; gnt=9'b000001000 throughout packet even if req_vld[3] drops 1 cycle.
REQ-034 Backpressure: out_rdy=0 with out_vld=1 for 5 cycles -> out_dat stable, req_rdy=0; out_rdy=1 -> next beat loaded same cycle, no bubble.
REQ-035 Wrap: only req 8 then req 0 valid, lst=1 -> ptr 8 -> 0 -> 1, grant to 0 immediately after 8.
REQ-036 Async reset mid-packet: rst_n low between cycles during LOCKED on req 5 -> out_vld=0 immediately, after release all valid -> first out_dat=0.

Source files
------------

// File: rtl/arb_rr_mux.sv
// Round-robin arbiter and mux: grants one requester per packet and forwards its beats to one registered output.
// Latency: a beat accepted in cycle N is presented on out_* in cycle N+1, at one beat per cycle sustained.
// Backpressure: out_vld & ~out_rdy freezes the output register and deasserts every req_rdy.
module arb_rr_mux #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req_vld,
  input  logic [WIDTH-1:0]     req_lst,
  input  DAT_T [WIDTH-1:0]     req_dat,
  output logic [WIDTH-1:0]     req_rdy,
  output logic                 out_vld,
  output logic                 out_lst,
  output DAT_T                 out_dat,
  input  logic                 out_rdy,
  output logic [WIDTH-1:0]     gnt
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = $bits(DAT_T);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t                     state_q;
  logic   [WIDTH-1:0]         owner_q;
  logic   [PW-1:0]            ptr_q;
  logic   [PW-1:0]            ptr_d;
  logic                       out_vld_q;
  logic                       out_lst_q;
  DAT_T                       out_dat_q;

  logic   [WIDTH-1:0][DW-1:0] req_dat_flat;
  logic   [DW-1:0]            mux_dat;
  logic                       mux_lst;
  logic   [PW-1:0]            xfer_idx;
  logic   [PW:0]              scan;
  logic                       found;
  logic                       acc;
  logic                       xfer;

  assign req_dat_flat = req_dat;

  // Output register can accept a new beat when empty or draining this cycle.
  assign acc     = ~out_vld_q | out_rdy;
  assign req_rdy = acc ? gnt : '0;
  assign xfer    = |(req_vld & req_rdy);

  assign out_vld = out_vld_q;
  assign out_lst = out_lst_q;
  assign out_dat = out_dat_q;

  // Grant: packet owner while locked, otherwise first valid requester scanning cyclically from ptr.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    scan  = '0;
    if (state_q == LOCKED) begin
      gnt = owner_q;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        scan = {1'b0, ptr_q} + (PW+1)'(k);
        if (scan >= (PW+1)'(WIDTH)) begin
          scan = scan - (PW+1)'(WIDTH);
        end
        if (!found && req_vld[scan[PW-1:0]]) begin
          gnt[scan[PW-1:0]] = 1'b1;
          found             = 1'b1;
        end
      end
    end
  end

  // One-hot AND-OR mux of data and last flag, plus the granted index for the pointer update.
  always_comb begin
    mux_dat  = '0;
    mux_lst  = 1'b0;
    xfer_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mux_dat = mux_dat | (req_dat_flat[i] & {DW{gnt[i]}});
      mux_lst = mux_lst | (req_lst[i] & gnt[i]);
      if (gnt[i]) begin
        xfer_idx = PW'(i);
      end
    end
  end

  // Pointer moves to the requester after the one that just closed a packet.
  always_comb begin
    ptr_d = (xfer_idx == PW'(WIDTH-1)) ? '0 : xfer_idx + PW'(1);
  end

  // Lock FSM, round-robin pointer and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= UNLOCKED;
      owner_q   <= '0;
      ptr_q     <= '0;
      out_vld_q <= 1'b0;
      out_lst_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      if (xfer) begin
        out_vld_q <= 1'b1;
        out_dat_q <= DAT_T'(mux_dat);
        out_lst_q <= mux_lst;
        if (mux_lst) begin
          state_q <= UNLOCKED;
          owner_q <= '0;
          ptr_q   <= ptr_d;
        end else begin
          state_q <= LOCKED;
          owner_q <= gnt;
        end
      end else if (out_rdy) begin
        out_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_rr_mux.sv
// Bench for arb_rr_mux with 9 requesters whose data equals their index.
// Directed scenarios plus randomized traffic against a queue-free behavioural model.
// Output is never stalled beyond the bench's own out_rdy choices.
module tb_arb_rr_mux;

  localparam int W = 9;

  logic              clk;
  logic              rst_n;
  logic [W-1:0]      req_vld;
  logic [W-1:0]      req_lst;
  logic [W-1:0][7:0] req_dat;
  logic [W-1:0]      req_rdy;
  logic              out_vld;
  logic              out_lst;
  logic [7:0]        out_dat;
  logic              out_rdy;
  logic [W-1:0]      gnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state: plain integers for pointer and owner index.
  int         m_ptr;
  int         m_owner;
  bit         m_lock;
  bit         m_ovld;
  bit         m_olst;
  logic [7:0] m_odat;

  arb_rr_mux #(
    .DAT_T (logic [7:0]),
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_vld),
    .req_lst (req_lst),
    .req_dat (req_dat),
    .req_rdy (req_rdy),
    .out_vld (out_vld),
    .out_lst (out_lst),
    .out_dat (out_dat),
    .out_rdy (out_rdy),
    .gnt     (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_idx();
    if (m_lock) return m_owner;
    for (int k = 0; k < W; k++) begin
      if (req_vld[(m_ptr + k) % W]) return (m_ptr + k) % W;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_gnt();
    int g;
    g = exp_idx();
    if (g < 0) return '0;
    return W'(1) << g;
  endfunction

  function automatic logic [W-1:0] exp_rdy();
    if (!m_ovld || out_rdy) return exp_gnt();
    return '0;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_lock = 0;
    m_ovld = 0; m_olst = 0; m_odat = '0;
  endtask

  task automatic model_edge();
    int g;
    bit acc;
    g   = exp_idx();
    acc = !m_ovld || out_rdy;
    if (acc && g >= 0 && req_vld[g]) begin
      m_ovld = 1;
      m_odat = 8'(g);
      m_olst = req_lst[g];
      if (req_lst[g]) begin
        m_lock = 0;
        m_ptr  = (g + 1) % W;
      end else begin
        m_lock  = 1;
        m_owner = g;
      end
    end else if (out_rdy) begin
      m_ovld = 0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_vld = W'($urandom);
      req_lst = W'($urandom);
      out_rdy = 1'b1;
      #1;
      n_cmp++;
      if (gnt !== exp_gnt()) begin
        n_bad++; $display("FAIL reset_gnt c=%0d got %b want %b", c, gnt, exp_gnt());
      end
      n_cmp++;
      if (req_rdy !== exp_gnt()) begin
        n_bad++; $display("FAIL reset_rdy c=%0d got %b want %b", c, req_rdy, exp_gnt());
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({out_vld, out_lst, out_dat} !== 10'd0) begin
        n_bad++; $display("FAIL reset_out c=%0d got vld=%b lst=%b dat=%0d want all zero", c, out_vld, out_lst, out_dat);
      end
    end
    @(negedge clk);
    req_vld = '0;
    rst_n   = 1'b1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_vld = '0; req_lst = '1; out_rdy = 1'b1;
      #1;
      n_cmp++;
      if (gnt !== '0 || req_rdy !== '0) begin
        n_bad++; $display("FAIL idle_gnt c=%0d got gnt=%b rdy=%b want 0", c, gnt, req_rdy);
      end
      @(posedge clk); model_edge(); #1;
      n_cmp++;
      if (out_vld !== 1'b0) begin
        n_bad++; $display("FAIL idle_vld c=%0d got %b want 0", c, out_vld);
      end
    end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      req_vld = '1; req_lst = '1; out_rdy = 1'b1;
      #1;
      n_cmp++;
      if (gnt !== (W'(1) << (k % W))) begin
        n_bad++; $display("FAIL rr_gnt k=%0d got %b want %b", k, gnt, W'(1) << (k % W));
      end
      @(posedge clk); model_edge(); #1;
      n_cmp++;
      if (out_vld !== 1'b1 || out_dat !== 8'(k % W)) begin
        n_bad++; $display("FAIL rr_out k=%0d got vld=%b dat=%0d want vld=1 dat=%0d", k, out_vld, out_dat, k % W);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_vld = '1; req_lst = '1; out_rdy = 1'b0;
      #1;
      n_cmp++;
      if (req_rdy !== '0) begin
        n_bad++; $display("FAIL bp_rdy c=%0d got %b want 0", c, req_rdy);
      end
      @(posedge clk); model_edge(); #1;
      n_cmp++;
      if (out_vld !== 1'b1 || out_dat !== 8'd8 || out_lst !== 1'b1) begin
        n_bad++; $display("FAIL bp_hold c=%0d got vld=%b dat=%0d want vld=1 dat=8", c, out_vld, out_dat);
      end
    end
    @(negedge clk);
    out_rdy = 1'b1;
    #1;
    n_cmp++;
    if (req_rdy !== 9'b000000001) begin
      n_bad++; $display("FAIL bp_release_rdy got %b want 000000001", req_rdy);
    end
    @(posedge clk); model_edge(); #1;
    n_cmp++;
    if (out_vld !== 1'b1 || out_dat !== 8'd0) begin
      n_bad++; $display("FAIL bp_release_out got vld=%b dat=%0d want vld=1 dat=0", out_vld, out_dat);
    end
  endtask

  task automatic test_packet_lock();
    bit         v3[5]   = '{1, 0, 1, 1, 1};
    bit         l3[5]   = '{0, 0, 0, 1, 1};
    logic [W-1:0] eg[5] = '{9'b000001000, 9'b000001000, 9'b000001000, 9'b000001000, 9'b000010000};
    bit         ev[5]   = '{1, 0, 1, 1, 1};
    int         ed[5]   = '{3, 3, 3, 3, 4};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_vld = (W'(v3[c]) << 3) | 9'b000010000;
      req_lst = (W'(l3[c]) << 3) | 9'b000010000;
      out_rdy = 1'b1;
      #1;
      n_cmp++;
      if (gnt !== eg[c]) begin
        n_bad++; $display("FAIL lock_gnt c=%0d got %b want %b", c, gnt, eg[c]);
      end
      @(posedge clk); model_edge(); #1;
      n_cmp++;
      if (out_vld !== ev[c] || out_dat !== 8'(ed[c])) begin
        n_bad++; $display("FAIL lock_out c=%0d got vld=%b dat=%0d want vld=%b dat=%0d", c, out_vld, out_dat, ev[c], ed[c]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] vs[3] = '{9'b100000000, 9'b100000001, 9'b100000001};
    logic [W-1:0] eg[3] = '{9'b100000000, 9'b000000001, 9'b100000000};
    int           ed[3] = '{8, 0, 8};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_vld = vs[c]; req_lst = '1; out_rdy = 1'b1;
      #1;
      n_cmp++;
      if (gnt !== eg[c]) begin
        n_bad++; $display("FAIL wrap_gnt c=%0d got %b want %b", c, gnt, eg[c]);
      end
      @(posedge clk); model_edge(); #1;
      n_cmp++;
      if (out_vld !== 1'b1 || out_dat !== 8'(ed[c])) begin
        n_bad++; $display("FAIL wrap_out c=%0d got vld=%b dat=%0d want vld=1 dat=%0d", c, out_vld, out_dat, ed[c]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_vld = 9'b000100000; req_lst = '0; out_rdy = 1'b1;
    @(posedge clk); model_edge(); #1;
    n_cmp++;
    if (out_vld !== 1'b1 || out_dat !== 8'd5) begin
      n_bad++; $display("FAIL arst_pre got vld=%b dat=%0d want vld=1 dat=5", out_vld, out_dat);
    end
    @(negedge clk);
    req_vld = '1; req_lst = '1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (out_vld !== 1'b0) begin
      n_bad++; $display("FAIL arst_vld got %b want 0", out_vld);
    end
    n_cmp++;
    if (gnt !== 9'b000000001) begin
      n_bad++; $display("FAIL arst_gnt got %b want 000000001", gnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); model_edge(); #1;
    n_cmp++;
    if (out_vld !== 1'b1 || out_dat !== 8'd0) begin
      n_bad++; $display("FAIL arst_first got vld=%b dat=%0d want vld=1 dat=0", out_vld, out_dat);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req_vld = W'($urandom);
      req_lst = W'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      n_cmp++;
      if (gnt !== exp_gnt()) begin
        n_bad++; $display("FAIL rnd_gnt c=%0d got %b want %b", c, gnt, exp_gnt());
      end
      n_cmp++;
      if (req_rdy !== exp_rdy()) begin
        n_bad++; $display("FAIL rnd_rdy c=%0d got %b want %b", c, req_rdy, exp_rdy());
      end
      @(posedge clk); model_edge(); #1;
      n_cmp++;
      if (out_vld !== m_ovld || out_lst !== m_olst || out_dat !== m_odat) begin
        n_bad++; $display("FAIL rnd_out c=%0d got vld=%b lst=%b dat=%0d want vld=%b lst=%b dat=%0d",
                          c, out_vld, out_lst, out_dat, m_ovld, m_olst, m_odat);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    req_vld = '0;
    req_lst = '0;
    out_rdy = 1'b1;
    for (int i = 0; i < W; i++) req_dat[i] = 8'(i);
    model_reset();
    test_reset();
    test_idle();
    test_round_robin();
    test_backpressure();
    test_packet_lock();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
